// File: rtl/icache_if.sv
// Fetch-side and refill-side signal bundle for icache_assoc.
// The cache connects through the slave modport; the fetch unit / memory model drive the master side.
interface icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_ready;
    logic                  cpu_valid;
    logic [DATA_WIDTH-1:0] cpu_data;
    logic                  flush;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] mem_data;

    modport slave (
        input  cpu_req, cpu_addr, flush, mem_valid, mem_data,
        output cpu_ready, cpu_valid, cpu_data, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, flush, mem_valid, mem_data,
        input  cpu_ready, cpu_valid, cpu_data, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with line refill, flush and round-robin replacement.
// Define ICACHE_PERF_EN to add saturating hit_count / miss_count outputs.
module icache_assoc #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 3,
    parameter int WAYS         = 2,
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
    input logic      clk,
    input logic      rst,
    icache_if.slave  bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int CACHE_DEPTH = 1 << INDEX_WIDTH;
    localparam int WORDS       = 1 << OFFSET_WIDTH;
    localparam int PTR_W       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP, S_FLUSH} state_t;
    state_t state, state_n;

    logic [WAYS-1:0]       valid_q [CACHE_DEPTH];
    logic [PTR_W-1:0]      ptr_q   [CACHE_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_q   [CACHE_DEPTH][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [CACHE_DEPTH][WAYS][WORDS];

    logic [TAG_WIDTH-1:0]    req_tag, lat_tag;
    logic [INDEX_WIDTH-1:0]  req_idx, lat_idx, fcnt_q;
    logic [OFFSET_WIDTH-1:0] req_off, lat_off, beat_q;
    logic [PTR_W-1:0]        hit_way, victim, victim_q;
    logic [DATA_WIDTH-1:0]   req_word_q;
    logic                    hit, accept, flush_go, flush_pend_q;
    logic                    refill_beat, last_beat;
    logic                    unused_addr_bits;

    assign req_off = bus.cpu_addr[OFFSET_WIDTH+1:2];
    assign req_idx = bus.cpu_addr[INDEX_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
    assign req_tag = bus.cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH+2];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    assign refill_beat = (state == S_REFILL) && bus.mem_valid && bus.mem_req;
    assign last_beat   = refill_beat && (&beat_q);

    // Tag compare and victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = ptr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim = PTR_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.cpu_ready = 1'b0;
        accept        = 1'b0;
        flush_go      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.flush || flush_pend_q) begin
                    flush_go = 1'b1;
                    state_n  = S_FLUSH;
                end else begin
                    bus.cpu_ready = 1'b1;
                    accept        = bus.cpu_req;
                    if (bus.cpu_req && !hit) state_n = S_REFILL;
                end
            end
            S_REFILL: if (last_beat) state_n = S_RESP;
            S_RESP:   state_n = S_IDLE;
            S_FLUSH:  if (&fcnt_q) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.cpu_valid <= 1'b0;
            bus.cpu_data  <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            flush_pend_q  <= 1'b0;
            beat_q        <= '0;
            fcnt_q        <= '0;
            for (int s = 0; s < CACHE_DEPTH; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            bus.cpu_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush_go) flush_pend_q <= 1'b0;
                    if (accept && hit) begin
                        bus.cpu_valid <= 1'b1;
                        bus.cpu_data  <= data_q[req_idx][hit_way][req_off];
                    end else if (accept) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {req_tag, req_idx, {(OFFSET_WIDTH + 2){1'b0}}};
                        beat_q       <= '0;
                    end
                end
                S_REFILL: begin
                    if (bus.flush) flush_pend_q <= 1'b1;
                    if (refill_beat) beat_q <= beat_q + 1'b1;
                    if (last_beat) begin
                        valid_q[lat_idx][victim_q] <= 1'b1;
                        if (victim_q == ptr_q[lat_idx])
                            ptr_q[lat_idx] <= (ptr_q[lat_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[lat_idx] + 1'b1;
                        bus.mem_req   <= 1'b0;
                        bus.cpu_valid <= 1'b1;
                        // The requested word may be the beat arriving right now.
                        bus.cpu_data  <= (lat_off == beat_q) ? bus.mem_data : req_word_q;
                    end
                end
                S_RESP: if (bus.flush) flush_pend_q <= 1'b1;
                S_FLUSH: begin
                    valid_q[fcnt_q] <= '0;
                    ptr_q[fcnt_q]   <= '0;
                    fcnt_q          <= fcnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Line storage and miss context carry no reset; beats are dropped during reset.
    always_ff @(posedge clk) begin
        if (accept && !hit) begin
            lat_tag  <= req_tag;
            lat_idx  <= req_idx;
            lat_off  <= req_off;
            victim_q <= victim;
        end
        if (rst && refill_beat) begin
            data_q[lat_idx][victim_q][beat_q] <= bus.mem_data;
            if (beat_q == lat_off) req_word_q <= bus.mem_data;
            if (last_beat) tag_q[lat_idx][victim_q] <= lat_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst || flush_go) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit && !(&hit_count))    hit_count  <= hit_count + 32'd1;
            if (!hit && !(&miss_count))  miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule
